inst_rom_loader: RTL and testbench
==================================

// Module: inst_rom_loader
// PURPOSE
//  Writer side of the instruction store: accepts a program as a byte stream (valid/ready) and
//  writes 32-bit words into the instruction RAM that the fetch path reads by byte address.
//  Stored words use the swapped lane order the fetch path undoes on read (SPIM compatible).
//  Holds the CPU in reset while loading; pulses done when the image is complete.
// PARAMETERS
//  ADDR_WIDTH  5  log2 of instruction-memory depth in words
//  SWAP_BYTES  1  1: first stream byte -> wdata[31:24]; 0: first stream byte -> wdata[7:0]
// PORTS
//  clock      in   1             system clock, all state on rising edge
//  reset      in   1             synchronous, active-high
//  start      in   1             1-cycle load request, sampled only in IDLE
//  num_words  in   ADDR_WIDTH+1  image length in words, sampled with start
//  s_valid    in   1             byte stream valid
//  s_data     in   8             byte stream data, memory byte order (address 0 first)
//  s_ready    out  1             loader can accept a byte
//  mem_we     out  1             1-cycle instruction-RAM write strobe
//  mem_addr   out  32            byte address; word index in [ADDR_WIDTH+1:2], [1:0]=0
//  mem_wdata  out  32            assembled word
//  busy       out  1             load in progress
//  cpu_hold   out  1             CPU reset request; equals busy
//  done       out  1             1-cycle pulse at end of load
//  err        out  1             sticky error, cleared by next accepted start
// BEHAVIOUR
//  - Reset: state=IDLE; s_ready, mem_we, busy, cpu_hold, done, err = 0; mem_addr, mem_wdata = 0.
//  - All outputs registered; handshake = s_valid & s_ready on a rising edge.
//  - FSM IDLE -> LOAD -> (CHECK if LOADER_CHECKSUM_EN) -> FIN -> IDLE.
//  - IDLE: s_ready=0. start & num_words==0 -> FIN (done pulse, no writes).
//    start & num_words>2**ADDR_WIDTH -> err=1, stay IDLE, no done. Else -> LOAD, err=0, word_idx=0.
//  - LOAD: s_ready=1 except the cycle mem_we is high (one bubble per word).
//    Byte counter 0..3; SWAP_BYTES=1: word <= {word[23:0],s_data}; =0: word <= {s_data,word[31:8]}.
//    4th byte: next cycle mem_we=1, mem_addr={word_idx,2'b00}, mem_wdata=word; word_idx++.
//    Write of word num_words-1 -> next state (FIN or CHECK); s_ready drops same cycle as that write.
//  - FIN: done=1 for exactly one cycle, busy/cpu_hold drop with it -> IDLE.
//  - busy=cpu_hold=1 in every non-IDLE state. start while busy is ignored.
//  - s_valid with s_ready=0 is not consumed; stream must hold data until handshake.
//  - Reset mid-load: FSM to IDLE, partial word discarded; already-written RAM words are untouched.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: running XOR of all written words (as stored); after the last word,
//   CHECK accepts 4 more bytes assembled identically (no write); mismatch -> err=1; then FIN, done pulses.
//  Undefined: no CHECK state, no checksum logic, err only from length overflow.
// STRUCTURE
//  Shared package inst_mem_pkg: INST_ADDR_WIDTH default, loader state enum
//   (LDR_IDLE, LDR_LOAD, LDR_CHECK, LDR_FIN), word/byte-address typedefs.
//  One sub-module: byte_to_word_packer (byte counter, shift register, SWAP_BYTES lane order,
//   word_valid pulse); FSM, address counter and checksum stay in top.
// TESTING
//  - start, num_words=2, bytes 0A 00 08 20 2A 00 09 20 (SWAP_BYTES=1) -> writes addr 0 = 0x0A000820,
//    addr 4 = 0x2A000920, done one cycle after last mem_we, cpu_hold high throughout.
//  - SWAP_BYTES=0, same first 4 bytes -> mem_wdata=0x2008000A.
//  - num_words=32, s_valid toggled every other cycle -> 32 writes, addrs 0x00..0x7C, no lost/duplicate bytes.
//  - num_words=33 -> err=1, no writes, no done; num_words=0 -> done pulse, no writes, err=0.
//  - reset asserted after 6 bytes of a 4-word load -> next cycle all outputs at reset values, only addr 0 written.
//  - LOADER_CHECKSUM_EN, words 0x11111111,0x22222222, checksum bytes -> 0x33333333 -> err=0;
//    wrong checksum -> err=1, done still pulses.

Source files
------------

// File: rtl/inst_mem_pkg.sv
// Shared instruction-memory definitions: default depth, loader FSM states and word/address types.
package inst_mem_pkg;

    localparam int INST_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        LDR_IDLE,
        LDR_LOAD,
        LDR_CHECK,
        LDR_FIN
    } ldr_state_t;

    typedef logic [31:0] word_t;
    typedef logic [31:0] byte_addr_t;

endpackage

// File: rtl/inst_rom_loader_if.sv
// Byte-stream valid/ready channel feeding the instruction-store loader.
interface inst_rom_loader_if;

    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/byte_to_word_packer.sv
// Collects four accepted stream bytes into one 32-bit word; word_valid pulses the cycle after the 4th byte.
module byte_to_word_packer
    import inst_mem_pkg::*;
#(
    parameter int SWAP_BYTES = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       last_byte,
    output logic       word_valid,
    output word_t      word
);

    logic [1:0] byte_cnt;
    word_t      shreg;
    word_t      shreg_next;

    // Lane order: SWAP_BYTES puts the first stream byte in the MSB lane.
    always_comb begin
        shreg_next = shreg;
        if (SWAP_BYTES != 0) shreg_next = {shreg[23:0], byte_data};
        else                 shreg_next = {byte_data, shreg[31:8]};
    end

    assign last_byte = (byte_cnt == 2'd3);

    always_ff @(posedge clock) begin
        if (reset) begin
            byte_cnt   <= 2'd0;
            shreg      <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                byte_cnt <= 2'd0;
            end else if (byte_valid) begin
                shreg    <= shreg_next;
                byte_cnt <= byte_cnt + 2'd1;
                if (last_byte) begin
                    word_valid <= 1'b1;
                    word       <= shreg_next;
                end
            end
        end
    end

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction-store writer: byte stream -> 32-bit RAM writes, holds the CPU while loading.
// Optional LOADER_CHECKSUM_EN adds an XOR checksum word after the image.
//  state     | meaning
//  LDR_IDLE  | waiting for start, stream not accepted
//  LDR_LOAD  | accepting image bytes, one RAM write per 4 bytes
//  LDR_CHECK | accepting 4 checksum bytes, compared against XOR of stored words
//  LDR_FIN   | done pulse, release CPU
module inst_rom_loader
    import inst_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = INST_ADDR_WIDTH,
    parameter int SWAP_BYTES = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_WIDTH:0] num_words,
    inst_rom_loader_if.slave    s,
    output logic                mem_we,
    output byte_addr_t          mem_addr,
    output word_t               mem_wdata,
    output logic                busy,
    output logic                cpu_hold,
    output logic                done,
    output logic                err
);

    localparam logic [ADDR_WIDTH:0]   DEPTH   = (ADDR_WIDTH+1)'(2 ** ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    ldr_state_t            state;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [ADDR_WIDTH-1:0] last_idx;
    logic                  s_ready_q;
    logic                  hs;
    logic                  pk_last;
    logic                  pk_valid;
    word_t                 pk_word;

    assign hs        = s.s_valid & s_ready_q;
    assign s.s_ready = s_ready_q;
    assign mem_addr  = {{(30-ADDR_WIDTH){1'b0}}, word_idx, 2'b00};
    assign mem_wdata = pk_word;
    assign cpu_hold  = busy;

    byte_to_word_packer #(.SWAP_BYTES(SWAP_BYTES)) u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (state == LDR_IDLE),
        .byte_valid (hs),
        .byte_data  (s.s_data),
        .last_byte  (pk_last),
        .word_valid (pk_valid),
        .word       (pk_word)
    );

`ifdef LOADER_CHECKSUM_EN
    word_t csum;
    // The checksum word goes through the packer too but must never reach the RAM.
    assign mem_we = pk_valid && (state == LDR_LOAD);
`else
    assign mem_we = pk_valid;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= LDR_IDLE;
            s_ready_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            word_idx  <= '0;
            last_idx  <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                LDR_IDLE: begin
                    if (start) begin
                        if (num_words == '0) begin
                            state <= LDR_FIN;
                            busy  <= 1'b1;
                            done  <= 1'b1;
                            err   <= 1'b0;
                        end else if (num_words > DEPTH) begin
                            err <= 1'b1;
                        end else begin
                            state     <= LDR_LOAD;
                            busy      <= 1'b1;
                            err       <= 1'b0;
                            s_ready_q <= 1'b1;
                            word_idx  <= '0;
                            last_idx  <= num_words[ADDR_WIDTH-1:0] - IDX_ONE;
`ifdef LOADER_CHECKSUM_EN
                            csum      <= '0;
`endif
                        end
                    end
                end
                LDR_LOAD: begin
                    // Drop ready on the 4th byte so the write cycle is a bubble.
                    if (hs && pk_last) s_ready_q <= 1'b0;
                    if (pk_valid) begin
                        word_idx <= word_idx + IDX_ONE;
`ifdef LOADER_CHECKSUM_EN
                        csum <= csum ^ pk_word;
`endif
                        if (word_idx == last_idx) begin
`ifdef LOADER_CHECKSUM_EN
                            state     <= LDR_CHECK;
                            s_ready_q <= 1'b1;
`else
                            state <= LDR_FIN;
                            done  <= 1'b1;
`endif
                        end else begin
                            s_ready_q <= 1'b1;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                LDR_CHECK: begin
                    if (hs && pk_last) s_ready_q <= 1'b0;
                    if (pk_valid) begin
                        err   <= (pk_word != csum);
                        state <= LDR_FIN;
                        done  <= 1'b1;
                    end
                end
`endif
                LDR_FIN: begin
                    state <= LDR_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= LDR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Scoreboard bench for inst_rom_loader: two instances (SWAP_BYTES 1 and 0) share one random byte stream.
module tb_inst_rom_loader;
    import inst_mem_pkg::*;

    localparam int AW = 5;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   num_words = '0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = 8'h00;

    logic          mem_we1, mem_we0, busy1, busy0, hold1, hold0, done1, done0, err1, err0;
    logic [31:0]   addr1, addr0, wdata1, wdata0;

    inst_rom_loader_if if1 ();
    inst_rom_loader_if if0 ();
    assign if1.s_valid = s_valid;
    assign if1.s_data  = s_data;
    assign if0.s_valid = s_valid;
    assign if0.s_data  = s_data;

    inst_rom_loader #(.ADDR_WIDTH(AW), .SWAP_BYTES(1)) dut1 (
        .clock(clock), .reset(reset), .start(start), .num_words(num_words), .s(if1),
        .mem_we(mem_we1), .mem_addr(addr1), .mem_wdata(wdata1),
        .busy(busy1), .cpu_hold(hold1), .done(done1), .err(err1));

    inst_rom_loader #(.ADDR_WIDTH(AW), .SWAP_BYTES(0)) dut0 (
        .clock(clock), .reset(reset), .start(start), .num_words(num_words), .s(if0),
        .mem_we(mem_we0), .mem_addr(addr0), .mem_wdata(wdata0),
        .busy(busy0), .cpu_hold(hold0), .done(done0), .err(err0));

    always #5 clock = ~clock;

    wr_t        q1[$];
    wr_t        q0[$];
    wr_t        e1, e0;
    logic [7:0] img [0:127];
    int         vectors = 0;
    int         miscompares = 0;
    int         cycle = 0;
    int         done1_cnt = 0;
    int         done0_cnt = 0;
    int         last_we_cyc = 0;
    int         done_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clock) cycle++;

    // Monitor: every RAM write is popped against the reference queue.
    always @(negedge clock) begin
        if (mem_we1) begin
            last_we_cyc = cycle;
            if (q1.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_write_swap1: addr %h data %h with nothing expected", addr1, wdata1);
            end else begin
                e1 = q1.pop_front();
                check("write_swap1", {addr1, wdata1}, e1);
                check("hold_during_write", 64'(hold1), 64'd1);
            end
        end
        if (mem_we0) begin
            if (q0.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_write_swap0: addr %h data %h with nothing expected", addr0, wdata0);
            end else begin
                e0 = q0.pop_front();
                check("write_swap0", {addr0, wdata0}, e0);
            end
        end
        if (done1) begin done1_cnt++; done_cyc = cycle; end
        if (done0) done0_cnt++;
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctrl1"}, {if1.s_ready, mem_we1, busy1, hold1, done1, err1}, 64'd0);
        check({tag, "_ctrl0"}, {if0.s_ready, mem_we0, busy0, hold0, done0, err0}, 64'd0);
        check({tag, "_bus1"}, {addr1, wdata1}, 64'd0);
        check({tag, "_bus0"}, {addr0, wdata0}, 64'd0);
    endtask

    // All stimulus tasks start and end just after a rising edge.
    task automatic pulse_start(input int n);
        @(negedge clock);
        num_words = (AW+1)'(n);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  t;
        bit  r;
        t = 0;
        s_valid = 1'b1;
        s_data  = b;
        do begin
            @(negedge clock);
            r = if1.s_ready;
            @(posedge clock);
            t++;
        end while (!r && t < 64);
        #1;
        s_valid = 1'b0;
        if (!r) begin
            vectors++; miscompares++;
            $display("FAIL byte_accept_timeout: byte %h not accepted in %0d cycles", b, t);
        end
    endtask

    task automatic gap(input int mode);
        int g;
        g = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(2)) : 0;
        repeat (g) begin @(posedge clock); #1; end
    endtask

    task automatic fill_img(input int n);
        for (int i = 0; i < 4 * n; i++) img[i] = 8'($urandom);
    endtask

    // Reference: word i is bytes 4i..4i+3, MSB-first for swap, LSB-first otherwise.
    task automatic push_word(input int i);
        q1.push_back(wr_t'({32'(i * 4), img[4*i], img[4*i+1], img[4*i+2], img[4*i+3]}));
        q0.push_back(wr_t'({32'(i * 4), img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]}));
    endtask

    task automatic run_load(input int n, input int gap_mode, input bit bad_csum);
        int         d1, d0, t;
        bit         exp_err;
        logic [7:0] c [4];
        exp_err = 1'b0;
        for (int k = 0; k < 4; k++) c[k] = 8'h00;
        for (int i = 0; i < n; i++) begin
            push_word(i);
            for (int k = 0; k < 4; k++) c[k] = c[k] ^ img[4*i+k];
        end
        d1 = done1_cnt;
        d0 = done0_cnt;
        pulse_start(n);
        check("busy_hold_on_start", {busy1, hold1, busy0, hold0}, 64'hF);
        for (int i = 0; i < 4 * n; i++) begin
            send_byte(img[i]);
            gap(gap_mode);
        end
`ifdef LOADER_CHECKSUM_EN
        if (n > 0) begin
            if (bad_csum) c[0] = c[0] ^ 8'h5A;
            exp_err = bad_csum;
            for (int k = 0; k < 4; k++) send_byte(c[k]);
        end
`endif
        t = 0;
        while (done1_cnt == d1 && t < 64) begin @(posedge clock); #1; t++; end
        repeat (2) begin @(posedge clock); #1; end
        check("done_pulses_swap1", 64'(done1_cnt - d1), 64'd1);
        check("done_pulses_swap0", 64'(done0_cnt - d0), 64'd1);
        check("err_after_load", {err1, err0}, {62'd0, exp_err, exp_err});
        check("idle_after_load", {busy1, hold1, busy0, hold0, if1.s_ready}, 64'd0);
        check("writes_outstanding", 64'(q1.size() + q0.size()), 64'd0);
`ifndef LOADER_CHECKSUM_EN
        if (n > 0) check("done_after_last_write", 64'(done_cyc), 64'(last_we_cyc + 1));
`endif
    endtask

    initial begin
        int d1;
        repeat (3) @(posedge clock);
        #1;
        check_reset_vals("reset");
        reset = 1'b0;
        @(posedge clock); #1;

        // Directed two-word image.
        img[0] = 8'h0A; img[1] = 8'h00; img[2] = 8'h08; img[3] = 8'h20;
        img[4] = 8'h2A; img[5] = 8'h00; img[6] = 8'h09; img[7] = 8'h20;
        run_load(2, 0, 1'b0);

        // Full depth with valid toggling.
        fill_img(32);
        run_load(32, 1, 1'b0);

        // Length overflow: error, no writes, no done.
        d1 = done1_cnt;
        pulse_start(33);
        repeat (4) begin @(posedge clock); #1; end
        check("overflow_err", {err1, err0}, 64'd3);
        check("overflow_idle", {busy1, busy0, if1.s_ready}, 64'd0);
        check("overflow_no_done", 64'(done1_cnt - d1), 64'd0);

        // Empty image: done, no writes, error cleared.
        run_load(0, 0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            int n;
            n = int'($urandom_range(32, 1));
            fill_img(n);
            run_load(n, 2, 1'($urandom_range(1)));
        end

        // Reset after 6 bytes of a 4-word load: only word 0 reaches RAM.
        fill_img(4);
        push_word(0);
        pulse_start(4);
        for (int i = 0; i < 6; i++) send_byte(img[i]);
        reset = 1'b1;
        @(posedge clock); #1;
        check_reset_vals("midload_reset");
        reset = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        check("midload_writes", 64'(q1.size() + q0.size()), 64'd0);

        fill_img(3);
        run_load(3, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
